// File: rtl/wash_sequencer_if.sv
// Control/status bundle between the wash sequencer and its driver (mode selector / panel).
// master drives the panel inputs; slave is the sequencer itself.
interface wash_sequencer_if;
  logic       power_light;
  logic       start_pause;
  logic [2:0] current_model;
  logic [1:0] run_state;
  logic       finish;
  logic [1:0] phase;
  logic [5:0] remain_sec;
  logic       buzzer;

  modport master (
    output power_light, start_pause, current_model,
    input  run_state, finish, phase, remain_sec, buzzer
  );

  modport slave (
    input  power_light, start_pause, current_model,
    output run_state, finish, phase, remain_sec, buzzer
  );
endinterface

// File: rtl/wash_sequencer.sv
// Wash program sequencer: wash -> rinse -> spin on a 1 s prescaled tick, with pause/resume.
// Optional completion buzzer is built only when WASH_BUZZER_EN is defined.
module wash_sequencer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int WASH_T        = 9,
  parameter int RINSE_T       = 6,
  parameter int SPIN_T        = 3,
  parameter int BUZZ_T        = 2
) (
  input  logic             clk,
  input  logic             rst,
  wash_sequencer_if.slave  bus
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    pcnt_q, pcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [5:0]    remain_q, remain_d;
  logic [2:0]    mode_q, mode_d;
  logic          finish_q, finish_d;
  logic [1:0]    nph;
  logic          tick;

  // Enabled phases per program as {spin, rinse, wash}.
  function automatic logic [2:0] mode_en(input logic [2:0] m);
    case (m)
      3'd0:    mode_en = 3'b111;
      3'd1:    mode_en = 3'b001;
      3'd2:    mode_en = 3'b011;
      3'd3:    mode_en = 3'b110;
      3'd4:    mode_en = 3'b010;
      3'd5:    mode_en = 3'b100;
      default: mode_en = 3'b000;
    endcase
  endfunction

  function automatic logic [4:0] dur(input logic [1:0] p);
    case (p)
      2'b01:   dur = 5'(WASH_T);
      2'b10:   dur = 5'(RINSE_T);
      2'b11:   dur = 5'(SPIN_T);
      default: dur = 5'd0;
    endcase
  endfunction

  function automatic logic [5:0] total(input logic [2:0] en);
    total = (en[0] ? 6'(WASH_T) : 6'd0) + (en[1] ? 6'(RINSE_T) : 6'd0)
          + (en[2] ? 6'(SPIN_T) : 6'd0);
  endfunction

  // First enabled phase strictly after cur; 00 when the program is exhausted.
  function automatic logic [1:0] next_phase(input logic [2:0] en, input logic [1:0] cur);
    next_phase = 2'b00;
    for (int p = 3; p >= 1; p--) begin
      if (p > int'(cur) && en[p-1]) next_phase = 2'(p);
    end
  endfunction

  assign tick = (state_q == S_RUN) && (presc_q == PW'(TICKS_PER_SEC - 1));

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    pcnt_d   = pcnt_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    mode_d   = mode_q;
    finish_d = 1'b0;
    nph      = 2'b00;
    if (!bus.power_light) begin
      state_d  = S_IDLE;
      presc_d  = '0;
      pcnt_d   = 5'd0;
      phase_d  = 2'b00;
      remain_d = 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_pause && bus.current_model <= 3'd5) begin
            nph      = next_phase(mode_en(bus.current_model), 2'b00);
            mode_d   = bus.current_model;
            phase_d  = nph;
            pcnt_d   = dur(nph);
            remain_d = total(mode_en(bus.current_model));
            presc_d  = '0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_d  = '0;
            remain_d = remain_q - 6'd1;
            if (pcnt_q == 5'd1) begin
              nph = next_phase(mode_en(mode_q), phase_q);
              if (nph == 2'b00) begin
                state_d  = S_IDLE;
                finish_d = 1'b1;
                phase_d  = 2'b00;
                remain_d = 6'd0;
                pcnt_d   = 5'd0;
              end else begin
                phase_d = nph;
                pcnt_d  = dur(nph);
              end
            end else begin
              pcnt_d = pcnt_q - 5'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // Completion swallows a coincident pause request.
          if (bus.start_pause && !finish_d) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (bus.start_pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      pcnt_q   <= 5'd0;
      phase_q  <= 2'b00;
      remain_q <= 6'd0;
      mode_q   <= 3'd0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      pcnt_q   <= pcnt_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      mode_q   <= mode_d;
      finish_q <= finish_d;
    end
  end

  assign bus.run_state  = state_q;
  assign bus.finish     = finish_q;
  assign bus.phase      = phase_q;
  assign bus.remain_sec = remain_q;

`ifdef WASH_BUZZER_EN
  localparam int BUZ_CYC = BUZZ_T * TICKS_PER_SEC;
  localparam int BW      = $clog2(BUZ_CYC + 1);

  logic          buzzer_q, buzzer_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    buzzer_d = buzzer_q;
    bcnt_d   = bcnt_q;
    if (!bus.power_light || bus.start_pause) begin
      buzzer_d = 1'b0;
      bcnt_d   = '0;
    end else if (finish_q) begin
      buzzer_d = 1'b1;
      bcnt_d   = BW'(BUZ_CYC - 1);
    end else if (buzzer_q) begin
      if (bcnt_q == '0) buzzer_d = 1'b0;
      else              bcnt_d   = bcnt_q - BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buzzer_q <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      buzzer_q <= buzzer_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign bus.buzzer = buzzer_q;
`else
  assign bus.buzzer = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer at TICKS_PER_SEC=4: stimulus queues expected
// snapshots per cycle, a monitor pops and compares them and every finish pulse.
module tb_wash_sequencer;

`ifdef WASH_BUZZER_EN
  localparam logic BZ = 1'b1;
`else
  localparam logic BZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int         c;
    logic [1:0] rs;
    logic       fin;
    logic [1:0] ph;
    logic [5:0] rem;
    logic       bz;
  } exp_t;

  exp_t exp_q[$];
  int   fin_q[$];
  exp_t e_mon;
  int   f_mon;

  wash_sequencer_if bus ();

  wash_sequencer #(.TICKS_PER_SEC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ex(input int c, input logic [1:0] rs, input logic fin,
                    input logic [1:0] ph, input logic [5:0] rem, input logic bz);
    exp_t t;
    t.c = c; t.rs = rs; t.fin = fin; t.ph = ph; t.rem = rem; t.bz = bz;
    exp_q.push_back(t);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Raise start_pause so that it is sampled by posedge number c.
  task automatic go(input int c);
    wait_cyc(c - 1);
    bus.start_pause = 1'b1;
    @(negedge clk);
    bus.start_pause = 1'b0;
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
      e_mon = exp_q.pop_front();
      checks++;
      if (e_mon.c != cyc) begin
        errors++;
        $display("FAIL missed_sample cyc=%0d expected at %0d", cyc, e_mon.c);
      end else if ({bus.run_state, bus.finish, bus.phase, bus.remain_sec, bus.buzzer} !==
                   {e_mon.rs, e_mon.fin, e_mon.ph, e_mon.rem, e_mon.bz}) begin
        errors++;
        $display("FAIL outputs cyc=%0d got rs=%b fin=%b ph=%b rem=%0d bz=%b want rs=%b fin=%b ph=%b rem=%0d bz=%b",
                 cyc, bus.run_state, bus.finish, bus.phase, bus.remain_sec, bus.buzzer,
                 e_mon.rs, e_mon.fin, e_mon.ph, e_mon.rem, e_mon.bz);
      end
    end
    if (bus.finish === 1'b1) begin
      checks++;
      if (fin_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_finish got cyc=%0d want none", cyc);
      end else begin
        f_mon = fin_q.pop_front();
        if (f_mon != cyc) begin
          errors++;
          $display("FAIL finish_time got cyc=%0d want %0d", cyc, f_mon);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1;
    bus.power_light   = 1'b1;
    bus.start_pause   = 1'b0;
    bus.current_model = 3'd0;
    @(negedge clk);
    ex(3, 2'b00, 0, 2'b00, 6'd0, 0);
    ex(5, 2'b00, 0, 2'b00, 6'd0, 0);
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(6);

    // mode 0, selector changes to 3 mid-run and must be ignored
    s = cyc + 3;
    ex(s,      2'b01, 0, 2'b01, 6'd18, 0);
    ex(s + 35, 2'b01, 0, 2'b01, 6'd10, 0);
    ex(s + 36, 2'b01, 0, 2'b10, 6'd9,  0);
    ex(s + 59, 2'b01, 0, 2'b10, 6'd4,  0);
    ex(s + 60, 2'b01, 0, 2'b11, 6'd3,  0);
    ex(s + 71, 2'b01, 0, 2'b11, 6'd1,  0);
    ex(s + 72, 2'b00, 1, 2'b00, 6'd0,  0);
    ex(s + 73, 2'b00, 0, 2'b00, 6'd0,  BZ);
    ex(s + 80, 2'b00, 0, 2'b00, 6'd0,  BZ);
    ex(s + 81, 2'b00, 0, 2'b00, 6'd0,  0);
    fin_q.push_back(s + 72);
    bus.current_model = 3'd0;
    go(s);
    wait_cyc(s + 10);
    bus.current_model = 3'd3;
    wait_cyc(s + 85);

    // mode 5 with a 20-cycle pause after 5 run cycles
    s = cyc + 3;
    ex(s,      2'b01, 0, 2'b11, 6'd3, 0);
    ex(s + 4,  2'b01, 0, 2'b11, 6'd2, 0);
    ex(s + 5,  2'b10, 0, 2'b11, 6'd2, 0);
    ex(s + 15, 2'b10, 0, 2'b11, 6'd2, 0);
    ex(s + 25, 2'b10, 0, 2'b11, 6'd2, 0);
    ex(s + 26, 2'b01, 0, 2'b11, 6'd2, 0);
    ex(s + 29, 2'b01, 0, 2'b11, 6'd1, 0);
    ex(s + 32, 2'b01, 0, 2'b11, 6'd1, 0);
    ex(s + 33, 2'b00, 1, 2'b00, 6'd0, 0);
    ex(s + 34, 2'b00, 0, 2'b00, 6'd0, BZ);
    ex(s + 42, 2'b00, 0, 2'b00, 6'd0, 0);
    fin_q.push_back(s + 33);
    bus.current_model = 3'd5;
    go(s);
    go(s + 5);
    go(s + 26);
    wait_cyc(s + 45);

    // mode 2, power dropped during rinse on a tick cycle
    s = cyc + 3;
    ex(s,      2'b01, 0, 2'b01, 6'd15, 0);
    ex(s + 36, 2'b01, 0, 2'b10, 6'd6,  0);
    ex(s + 39, 2'b01, 0, 2'b10, 6'd6,  0);
    ex(s + 40, 2'b00, 0, 2'b00, 6'd0,  0);
    ex(s + 41, 2'b00, 0, 2'b00, 6'd0,  0);
    ex(s + 50, 2'b00, 0, 2'b00, 6'd0,  0);
    bus.current_model = 3'd2;
    go(s);
    wait_cyc(s + 39);
    bus.power_light = 1'b0;
    @(negedge clk);
    bus.power_light = 1'b1;
    wait_cyc(s + 52);

    // mode 4, start_pause on the final tick; then an ignored start (mode 6) clears the buzzer
    s = cyc + 3;
    ex(s,      2'b01, 0, 2'b10, 6'd6, 0);
    ex(s + 23, 2'b01, 0, 2'b10, 6'd1, 0);
    ex(s + 24, 2'b00, 1, 2'b00, 6'd0, 0);
    ex(s + 25, 2'b00, 0, 2'b00, 6'd0, BZ);
    ex(s + 27, 2'b00, 0, 2'b00, 6'd0, BZ);
    ex(s + 28, 2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 33, 2'b00, 0, 2'b00, 6'd0, 0);
    fin_q.push_back(s + 24);
    bus.current_model = 3'd4;
    go(s);
    go(s + 24);
    wait_cyc(s + 26);
    bus.current_model = 3'd6;
    go(s + 28);
    wait_cyc(s + 35);

    // invalid programs 6 and 7 from a clean idle
    s = cyc + 3;
    ex(s,      2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 4,  2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 10, 2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 14, 2'b00, 0, 2'b00, 6'd0, 0);
    bus.current_model = 3'd6;
    go(s);
    bus.current_model = 3'd7;
    go(s + 10);
    wait_cyc(s + 16);

    // mode 1, asynchronous reset mid-wash
    s = cyc + 3;
    ex(s,      2'b01, 0, 2'b01, 6'd9, 0);
    ex(s + 9,  2'b01, 0, 2'b01, 6'd7, 0);
    ex(s + 10, 2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 11, 2'b00, 0, 2'b00, 6'd0, 0);
    ex(s + 20, 2'b00, 0, 2'b00, 6'd0, 0);
    bus.current_model = 3'd1;
    go(s);
    wait_cyc(s + 9);
    #1 rst = 1'b1;
    wait_cyc(s + 11);
    rst = 1'b0;
    wait_cyc(s + 45);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_samples got %0d want 0", exp_q.size());
    end
    checks++;
    if (fin_q.size() != 0) begin
      errors++;
      $display("FAIL missing_finish got %0d pending want 0", fin_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
